simon_sequence_checker: RTL and testbench

Round controller for the Simon game. It sits directly downstream of the sequence converter. On start it latches the 40-bit one-hot step sequence (10 steps × 4 quadrants). Each round it plays back steps 0..round-1 on a quadrant-light output, paced by an external tick. It then compares player presses, taken from the cursor quadrant encoder's one-hot output, against the stored steps and reports win or lose.

---
 rtl/simon_sequence_checker.sv | 201 ++++++++++++++++++++
 tb/tb_simon_sequence_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_checker.sv
// Simon round controller: latches the step sequence on start, plays back
// steps 0..round-1 paced by tick, then checks player presses against the
// stored steps and reports win or lose.
//
// Pulse protocol: start, tick and press are single-cycle qualifiers sampled
// on the rising edge of CLOCK_50. There is no back-pressure. A pulse is
// either consumed in the cycle it is high or ignored, depending on the
// current state. quarterSelected is only looked at in a cycle where press
// is high.
module simon_sequence_checker #(
  parameter int NUM_STEPS     = 10,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NUM_STEPS-1:0] inSequence,
  input  logic                   tick,
  input  logic                   press,
  input  logic [3:0]             quarterSelected,
  output logic [3:0]             showQuarter,
  output logic                   awaitingInput,
  output logic [3:0]             round,
  output logic [3:0]             stepIndex,
  output logic                   win,
  output logic                   lose,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHOW_ON    = 3'd1,
    SHOW_OFF   = 3'd2,
    WAIT_INPUT = 3'd3,
    GAP        = 3'd4,
    WIN        = 3'd5,
    LOSE       = 3'd6
  } state_t;

  // Tick/timeout counters are 8 bits wide; each period parameter must be <= 256.
  localparam logic [7:0] ON_LAST      = 8'(ON_TICKS - 1);
  localparam logic [7:0] OFF_LAST     = 8'(OFF_TICKS - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP_TICKS - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);
  localparam logic [3:0] LAST_ROUND   = 4'(NUM_STEPS);

  state_t                 state_q, state_d;
  logic [4*NUM_STEPS-1:0] seq_q, seq_d;
  logic [3:0]             round_q, round_d;
  logic [3:0]             step_q, step_d;
  logic [7:0]             tick_cnt_q, tick_cnt_d;
  logic [7:0]             timeout_q, timeout_d;
  logic [3:0]             show_d;
  logic                   await_d, win_d, lose_d;
  logic [3:0]             expected_step;
  logic                   press_match;

  // Step k of a sequence; indices past the last step read as dark.
  function automatic logic [3:0] step_of(input logic [4*NUM_STEPS-1:0] seq,
                                         input logic [3:0] idx);
    logic [3:0] sel;
    sel = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (idx == 4'(k)) sel = seq[4*k +: 4];
    end
    return sel;
  endfunction

  // A press matches only with a single hot quadrant equal to the stored step.
  always_comb begin
    expected_step = step_of(seq_q, step_q);
    press_match   = (quarterSelected != 4'd0) &&
                    ((quarterSelected & (quarterSelected - 4'd1)) == 4'd0) &&
                    (quarterSelected == expected_step);
  end

  // Next-state and next-output logic; outputs are derived from the next state
  // so every output is registered and changes on the causing edge.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    round_d    = round_q;
    step_d     = step_q;
    tick_cnt_d = tick_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          seq_d      = inSequence;
          round_d    = 4'd1;
          step_d     = 4'd0;
          tick_cnt_d = 8'd0;
          timeout_d  = 8'd0;
          state_d    = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (tick) begin
          if (tick_cnt_q == ON_LAST) begin
            tick_cnt_d = 8'd0;
            state_d    = SHOW_OFF;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      SHOW_OFF: begin
        if (tick) begin
          if (tick_cnt_q == OFF_LAST) begin
            tick_cnt_d = 8'd0;
            if (step_q + 4'd1 < round_q) begin
              step_d  = step_q + 4'd1;
              state_d = SHOW_ON;
            end else begin
              step_d    = 4'd0;
              timeout_d = 8'd0;
              state_d   = WAIT_INPUT;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      WAIT_INPUT: begin
        // A press wins over a tick arriving in the same cycle.
        if (press) begin
          if (!press_match) begin
            state_d = LOSE;
          end else if (step_q + 4'd1 < round_q) begin
            step_d    = step_q + 4'd1;
            timeout_d = 8'd0;
          end else if (round_q == LAST_ROUND) begin
            state_d = WIN;
          end else begin
            round_d    = round_q + 4'd1;
            step_d     = 4'd0;
            tick_cnt_d = 8'd0;
            state_d    = GAP;
          end
        end else if (tick) begin
          if (timeout_q == TIMEOUT_LAST) begin
            state_d = LOSE;
          end else begin
            timeout_d = timeout_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tick_cnt_q == GAP_LAST) begin
            tick_cnt_d = 8'd0;
            state_d    = SHOW_ON;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    show_d  = (state_d == SHOW_ON) ? step_of(seq_d, step_d) : 4'd0;
    await_d = (state_d == WAIT_INPUT);
    win_d   = (state_d == WIN);
    lose_d  = (state_d == LOSE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      seq_q         <= '0;
      round_q       <= 4'd0;
      step_q        <= 4'd0;
      tick_cnt_q    <= 8'd0;
      timeout_q     <= 8'd0;
      showQuarter   <= 4'd0;
      awaitingInput <= 1'b0;
      win           <= 1'b0;
      lose          <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      round_q       <= round_d;
      step_q        <= step_d;
      tick_cnt_q    <= tick_cnt_d;
      timeout_q     <= timeout_d;
      showQuarter   <= show_d;
      awaitingInput <= await_d;
      win           <= win_d;
      lose          <= lose_d;
    end
  end

  assign round     = round_q;
  assign stepIndex = step_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_simon_sequence_checker.sv
// Bench for simon_sequence_checker: random sequences and random stray
// pulses, with expectations built from the game rules (lit/dark tick
// counts per step, round progression, timeout, win/lose).
module tb_simon_sequence_checker;

  localparam int N   = 10;
  localparam int ON  = 2;
  localparam int OFF = 1;
  localparam int GAP = 2;
  localparam int TO  = 10;

  logic        CLOCK_50 = 1'b0;
  logic        reset, start, tick, press;
  logic [39:0] inSequence;
  logic [3:0]  quarterSelected;
  logic [3:0]  showQuarter;
  logic        awaitingInput;
  logic [3:0]  round, stepIndex;
  logic        win, lose;
  logic [2:0]  dbg_state;

  simon_sequence_checker dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .start           (start),
    .inSequence      (inSequence),
    .tick            (tick),
    .press           (press),
    .quarterSelected (quarterSelected),
    .showQuarter     (showQuarter),
    .awaitingInput   (awaitingInput),
    .round           (round),
    .stepIndex       (stepIndex),
    .win             (win),
    .lose            (lose),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] seq_m [N];
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  // Idle clocks with random stray press/start pulses that must be ignored
  // (only used outside WAIT_INPUT and outside IDLE/WIN/LOSE).
  task automatic idle_stray(input int n);
    logic [63:0] rnd;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        press           = 1'b1;
        quarterSelected = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 5) == 0) begin
        rnd        = {$urandom(), $urandom()};
        start      = 1'b1;
        inSequence = rnd[39:0];
      end
      clk1();
      press = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic make_seq(input bit fixed, output logic [39:0] s);
    for (int k = 0; k < N; k++) begin
      seq_m[k] = 4'b0001 << $urandom_range(0, 3);
      s[4*k +: 4] = seq_m[k];
    end
    if (fixed) begin
      s = 40'h1248124812;
      for (int k = 0; k < N; k++) seq_m[k] = s[4*k +: 4];
    end
  endtask

  task automatic start_game(input bit fixed);
    logic [39:0] s;
    logic [63:0] rnd;
    make_seq(fixed, s);
    inSequence = s;
    start      = 1'b1;
    clk1();
    start      = 1'b0;
    rnd        = {$urandom(), $urandom()};
    inSequence = rnd[39:0];
    check("start_round", round, 4'd1);
    check("start_step", stepIndex, 4'd0);
    check("start_win", 4'(win), 4'd0);
    check("start_lose", 4'(lose), 4'd0);
    check("start_show", showQuarter, seq_m[0]);
  endtask

  // Playback of round r: each step lit ON ticks, dark OFF ticks, then WAIT_INPUT.
  task automatic play_round(input int r);
    logic [3:0] e;
    for (int k = 0; k < r; k++) begin
      repeat (ON) exp_q.push_back(seq_m[k]);
      repeat (OFF) exp_q.push_back(4'd0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idle_stray(3);
      check("playback_show", showQuarter, e);
      check("playback_await", 4'(awaitingInput), 4'd0);
      tick_once();
    end
    check("wait_await", 4'(awaitingInput), 4'd1);
    check("wait_round", round, 4'(r));
    check("wait_step", stepIndex, 4'd0);
    check("wait_show", showQuarter, 4'd0);
  endtask

  // Correct answers for round r, then the gap (or the win).
  task automatic answer_round(input int r);
    for (int k = 0; k < r; k++) begin
      repeat ($urandom_range(0, 3)) clk1();
      if ($urandom_range(0, 1) == 1) tick_once();
      quarterSelected = seq_m[k];
      press = 1'b1;
      clk1();
      press = 1'b0;
      if (k < r - 1) begin
        check("ans_step", stepIndex, 4'(k + 1));
        check("ans_await", 4'(awaitingInput), 4'd1);
      end
    end
    if (r == N) begin
      check("win_flag", 4'(win), 4'd1);
      check("win_await", 4'(awaitingInput), 4'd0);
      check("win_round", round, 4'(N));
      check("win_step", stepIndex, 4'(N - 1));
      check("win_show", showQuarter, 4'd0);
    end else begin
      check("next_round", round, 4'(r + 1));
      check("next_step", stepIndex, 4'd0);
      check("next_await", 4'(awaitingInput), 4'd0);
      check("next_lose", 4'(lose), 4'd0);
      for (int g = 0; g < GAP; g++) begin
        idle_stray(3);
        check("gap_show", showQuarter, 4'd0);
        check("gap_await", 4'(awaitingInput), 4'd0);
        tick_once();
      end
    end
  endtask

  task automatic press_value(input logic [3:0] q);
    quarterSelected = q;
    press = 1'b1;
    clk1();
    press = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_show"}, showQuarter, 4'd0);
    check({tag, "_await"}, 4'(awaitingInput), 4'd0);
    check({tag, "_round"}, round, 4'd0);
    check({tag, "_step"}, stepIndex, 4'd0);
    check({tag, "_win"}, 4'(win), 4'd0);
    check({tag, "_lose"}, 4'(lose), 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; press = 1'b0;
    quarterSelected = 4'd0; inSequence = 40'd0;
    clk1();
    clk1();
    check_all_zero("reset");
    reset = 1'b0;
    tick_once();
    press_value(4'b0001);
    check_all_zero("idle");

    // Fixed sequence: round 1, round 2, then a wrong press on step 1.
    start_game(1'b1);
    play_round(1);
    answer_round(1);
    play_round(2);
    press_value(seq_m[0]);
    check("a_step1", stepIndex, 4'd1);
    press_value(4'b0100);
    check("a_lose", 4'(lose), 4'd1);
    check("a_await", 4'(awaitingInput), 4'd0);
    check("a_round", round, 4'd2);
    check("a_show", showQuarter, 4'd0);
    press_value(seq_m[1]);
    tick_once();
    check("a_lose_hold", 4'(lose), 4'd1);
    check("a_round_hold", round, 4'd2);
    check("a_step_hold", stepIndex, 4'd1);

    // Timeout, with a correct press landing on the 9th tick.
    start_game(1'b0);
    play_round(1);
    answer_round(1);
    play_round(2);
    for (int i = 0; i < TO - 2; i++) begin
      repeat (3) clk1();
      tick_once();
    end
    repeat (3) clk1();
    quarterSelected = seq_m[0];
    press = 1'b1;
    tick  = 1'b1;
    clk1();
    press = 1'b0;
    tick  = 1'b0;
    check("to_press_lose", 4'(lose), 4'd0);
    check("to_press_step", stepIndex, 4'd1);
    for (int i = 0; i < TO - 1; i++) begin
      repeat (3) clk1();
      tick_once();
    end
    check("to_9_lose", 4'(lose), 4'd0);
    check("to_9_await", 4'(awaitingInput), 4'd1);
    repeat (3) clk1();
    tick_once();
    check("to_10_lose", 4'(lose), 4'd1);
    check("to_10_await", 4'(awaitingInput), 4'd0);
    check("to_10_round", round, 4'd2);

    // Full game to a win, with stray start/press pulses during playback.
    start_game(1'b0);
    for (int r = 1; r <= N; r++) begin
      play_round(r);
      answer_round(r);
    end
    repeat (2) clk1();
    tick_once();
    press_value(4'b0001);
    check("win_sticky", 4'(win), 4'd1);
    check("win_sticky_round", round, 4'(N));

    // Restart from WIN, reset during SHOW_ON.
    start_game(1'b0);
    tick_once();
    check("d_show_on", showQuarter, seq_m[0]);
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    check_all_zero("mid_reset");
    check("mid_reset_state", 4'(dbg_state), 4'd0);

    // Multi-hot press never matches.
    start_game(1'b0);
    play_round(1);
    press_value(4'b0011);
    check("multihot_lose", 4'(lose), 4'd1);
    check("multihot_await", 4'(awaitingInput), 4'd0);

    // Zero press never matches.
    start_game(1'b0);
    play_round(1);
    press_value(4'b0000);
    check("zero_lose", 4'(lose), 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
